// File: rtl/icache_refill_pkg.sv
// Shared types and width helpers for the I-cache line refill controller.
package icache_refill_pkg;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_REQ  = 3'd1,
      ST_FILL = 3'd2,
      ST_DONE = 3'd3,
      ST_GAP  = 3'd4
   } refill_state_t;

   localparam logic [1:0]  AR_BURST_STEP_ONE  = 2'd1;
   localparam int unsigned DEFAULT_LINE_WORDS = 8;

   // Byte-offset bits covered by one line.
   function automatic int unsigned line_ofs_bits(input int unsigned line_words);
      return $clog2(line_words) + 2;
   endfunction

   function automatic int unsigned beat_cnt_bits(input int unsigned line_words);
      return $clog2(line_words) + 1;
   endfunction

endpackage

// File: rtl/icache_refill_line_buffer.sv
// Line buffer for the refill controller: one write port, flat line read-out, one indexed read.
module refill_line_buffer
   import icache_refill_pkg::*;
#(
   parameter int unsigned LINE_WORDS = DEFAULT_LINE_WORDS,
   localparam int unsigned IW = $clog2(LINE_WORDS)
) (
   input  logic                    clk,
   input  logic                    we,
   input  logic [IW-1:0]           widx,
   input  logic [31:0]             wdata,
   output logic [32*LINE_WORDS-1:0] line,
   input  logic [IW-1:0]           ridx,
   output logic [31:0]             rdata
);

   // No reset: the controller masks the read-out until a line is complete.
   logic [31:0] mem [LINE_WORDS];

   always_ff @(posedge clk) begin
      if (we) mem[widx] <= wdata;
   end

   always_comb begin
      line = '0;
      for (int unsigned i = 0; i < LINE_WORDS; i++) begin
         line[32*i +: 32] = mem[i];
      end
   end

   assign rdata = mem[ridx];

endmodule

// File: rtl/icache_refill_ctrl.sv
// I-cache line refill controller: one miss -> one INCR read burst -> one-cycle line presentation.
// Optional critical-word forwarding is built when ICACHE_CRITICAL_WORD_FWD_EN is defined.
module icache_refill_ctrl
   import icache_refill_pkg::*;
#(
   parameter int unsigned LINE_WORDS = DEFAULT_LINE_WORDS,
   parameter int unsigned GAP_CYCLES = 2
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     miss_req,
   input  logic [31:0]              miss_addr,
   output logic                     miss_ready,
   output logic                     busy,
   output logic                     refill_valid,
   output logic [31:0]              refill_addr,
   output logic [32*LINE_WORDS-1:0] refill_line,
   output logic [31:0]              refill_word,
   output logic                     axi_ar_en,
   output logic [31:0]              cpu_rd_addr,
   output logic [7:0]               ar_burst_len,
   output logic [1:0]               ar_burst_step,
   input  logic [31:0]              cpu_rd_data,
   input  logic                     bus_rd_data_ready
`ifdef ICACHE_CRITICAL_WORD_FWD_EN
   ,
   output logic                     early_valid,
   output logic [31:0]              early_word
`endif
);

   localparam int unsigned OFS = line_ofs_bits(LINE_WORDS);
   localparam int unsigned IW  = OFS - 2;
   localparam int unsigned BW  = beat_cnt_bits(LINE_WORDS);
   localparam int unsigned GW  = $clog2(GAP_CYCLES) + 1;

   refill_state_t state, state_n;

   logic [BW-1:0]           beat_cnt;
   logic [IW-1:0]           word_idx;
   logic [31:0]             line_addr;
   logic                    line_valid;
   logic [GW-1:0]           gap_cnt;
   logic                    accept;
   logic                    beat_we;
   logic                    last_beat;
   logic                    show_line;
   logic [32*LINE_WORDS-1:0] buf_line;
   logic [31:0]             buf_word;
   logic                    unused_addr_lsbs;

   assign accept    = (state == ST_IDLE) && miss_req;
   // Beats are counted in REQ too, so a ready pulse on the REQ->FILL edge is kept.
   assign beat_we   = bus_rd_data_ready && ((state == ST_REQ) || (state == ST_FILL));
   assign last_beat = beat_we && (beat_cnt == BW'(LINE_WORDS - 1));

   always_comb begin
      state_n = state;
      case (state)
         ST_IDLE: if (accept) state_n = ST_REQ;
         ST_REQ:  state_n = ST_FILL;
         ST_FILL: if (last_beat) state_n = ST_DONE;
         ST_DONE: state_n = ST_GAP;
         ST_GAP:  if (gap_cnt == GW'(GAP_CYCLES - 2)) state_n = ST_IDLE;
         default: state_n = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= ST_IDLE;
         beat_cnt   <= '0;
         word_idx   <= '0;
         line_addr  <= '0;
         line_valid <= 1'b0;
         gap_cnt    <= '0;
      end else begin
         state <= state_n;
         if (accept) begin
            beat_cnt   <= '0;
            word_idx   <= miss_addr[OFS-1:2];
            line_addr  <= {miss_addr[31:OFS], {OFS{1'b0}}};
            line_valid <= 1'b0;
         end else if (beat_we) begin
            beat_cnt <= beat_cnt + 1'b1;
         end
         if (state == ST_DONE) begin
            line_valid <= 1'b1;
            gap_cnt    <= '0;
         end else if (state == ST_GAP) begin
            gap_cnt <= gap_cnt + 1'b1;
         end
      end
   end

   refill_line_buffer #(.LINE_WORDS(LINE_WORDS)) u_line_buffer (
      .clk   (clk),
      .we    (beat_we),
      .widx  (beat_cnt[IW-1:0]),
      .wdata (cpu_rd_data),
      .line  (buf_line),
      .ridx  (word_idx),
      .rdata (buf_word)
   );

   // The buffer has no reset; its contents are only exposed once a full line is in.
   assign show_line     = (state == ST_DONE) || line_valid;
   assign refill_line   = show_line ? buf_line : '0;
   assign refill_word   = show_line ? buf_word : '0;

   assign miss_ready    = (state == ST_IDLE);
   assign busy          = (state != ST_IDLE);
   assign axi_ar_en     = (state == ST_REQ) || (state == ST_FILL);
   assign refill_valid  = (state == ST_DONE);
   assign refill_addr   = line_addr;
   assign cpu_rd_addr   = line_addr;
   assign ar_burst_len  = 8'(LINE_WORDS - 1);
   assign ar_burst_step = AR_BURST_STEP_ONE;

   assign unused_addr_lsbs = &{1'b0, miss_addr[1:0]};

`ifdef ICACHE_CRITICAL_WORD_FWD_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         early_valid <= 1'b0;
         early_word  <= '0;
      end else begin
         early_valid <= beat_we && (beat_cnt[IW-1:0] == word_idx);
         if (beat_we && (beat_cnt[IW-1:0] == word_idx)) early_word <= cpu_rd_data;
      end
   end
`endif

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Self-checking bench for icache_refill_ctrl: timestamp-based transaction model plus directed literal checks.
module tb_icache_refill_ctrl;

   localparam int LW  = 8;
   localparam int GAP = 2;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              miss_req = 1'b0;
   logic [31:0]       miss_addr = '0;
   logic              miss_ready, busy, refill_valid, axi_ar_en;
   logic [31:0]       refill_addr, refill_word, cpu_rd_addr;
   logic [32*LW-1:0]  refill_line;
   logic [7:0]        ar_burst_len;
   logic [1:0]        ar_burst_step;
   logic [31:0]       cpu_rd_data = '0;
   logic              bus_rd_data_ready = 1'b0;
`ifdef ICACHE_CRITICAL_WORD_FWD_EN
   logic              early_valid;
   logic [31:0]       early_word;
`endif

   icache_refill_ctrl #(.LINE_WORDS(LW), .GAP_CYCLES(GAP)) dut (
      .clk               (clk),
      .reset             (reset),
      .miss_req          (miss_req),
      .miss_addr         (miss_addr),
      .miss_ready        (miss_ready),
      .busy              (busy),
      .refill_valid      (refill_valid),
      .refill_addr       (refill_addr),
      .refill_line       (refill_line),
      .refill_word       (refill_word),
      .axi_ar_en         (axi_ar_en),
      .cpu_rd_addr       (cpu_rd_addr),
      .ar_burst_len      (ar_burst_len),
      .ar_burst_step     (ar_burst_step),
      .cpu_rd_data       (cpu_rd_data),
      .bus_rd_data_ready (bus_rd_data_ready)
`ifdef ICACHE_CRITICAL_WORD_FWD_EN
      ,
      .early_valid       (early_valid),
      .early_word        (early_word)
`endif
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic chk_line(input string name, input logic [32*LW-1:0] act, input logic [32*LW-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
      end
   endtask

   // Model: a refill is "active" from the cycle after accept through the cycle the last beat
   // arrives; the line is presented the cycle after, and the controller is free GAP cycles later.
   int          cyc = 0;
   bit          m_active = 0;
   int          m_beats = 0;
   int          m_done = -1;
   int          m_free = 0;
   bit          m_shown = 0;
   logic [31:0] m_addr = '0;
   int          m_widx = 0;
   logic [31:0] m_line [LW];
   bit          m_early = 0;
   logic [31:0] m_early_word = '0;

   int valid_cnt = 0;
   int last_valid_cyc = -1;
   int last_rise_cyc = -1;
   int early_cnt = 0;
   logic prev_ar = 1'b0;

   initial for (int i = 0; i < LW; i++) m_line[i] = '0;

   always @(posedge clk) begin
      int p;
      bit p_idle;
      logic [32*LW-1:0] exp_line;
      p = cyc;
      cyc++;
      p_idle = !m_active && (p >= m_free);
      m_early = 0;
      if (reset) begin
         m_active = 0; m_free = 0; m_done = -1; m_shown = 0; m_addr = '0; m_widx = 0;
      end else if (p_idle) begin
         if (miss_req) begin
            m_active = 1;
            m_beats  = 0;
            m_shown  = 0;
            m_addr   = miss_addr & ~32'(LW*4 - 1);
            m_widx   = int'((miss_addr >> 2) % LW);
         end
      end else if (m_active && bus_rd_data_ready) begin
         m_line[m_beats] = cpu_rd_data;
         if (m_beats == m_widx) begin
            m_early = 1;
            m_early_word = cpu_rd_data;
         end
         m_beats++;
         if (m_beats == LW) begin
            m_active = 0;
            m_done   = cyc;
            m_free   = cyc + GAP;
            m_shown  = 1;
         end
      end
      exp_line = '0;
      if (m_shown) for (int i = 0; i < LW; i++) exp_line[32*i +: 32] = m_line[i];

      #1;
      if (cyc > 1) begin
         chk("miss_ready", 32'(miss_ready), 32'(!m_active && cyc >= m_free));
         chk("busy", 32'(busy), 32'(m_active || cyc < m_free));
         chk("axi_ar_en", 32'(axi_ar_en), 32'(m_active));
         chk("refill_valid", 32'(refill_valid), 32'(cyc == m_done));
         chk("cpu_rd_addr", cpu_rd_addr, m_addr);
         chk("refill_addr", refill_addr, m_addr);
         chk("ar_burst_len", 32'(ar_burst_len), 32'(LW - 1));
         chk("ar_burst_step", 32'(ar_burst_step), 32'd1);
         chk_line("refill_line", refill_line, exp_line);
         chk("refill_word", refill_word, m_shown ? m_line[m_widx] : 32'h0);
`ifdef ICACHE_CRITICAL_WORD_FWD_EN
         chk("early_valid", 32'(early_valid), 32'(m_early));
         if (m_early) chk("early_word", early_word, m_early_word);
         if (early_valid === 1'b1) early_cnt++;
`endif
      end
      if (refill_valid === 1'b1) begin
         valid_cnt++;
         last_valid_cyc = cyc;
      end
      if (axi_ar_en === 1'b1 && prev_ar !== 1'b1) last_rise_cyc = cyc;
      prev_ar = axi_ar_en;
   end

   task automatic wait_idle();
      int k = 0;
      while (miss_ready !== 1'b1 && k < 60) begin
         @(negedge clk);
         k++;
      end
      if (miss_ready !== 1'b1) begin
         checks++;
         failures++;
         $display("FAIL wait_idle timeout actual=%b required=1", miss_ready);
      end
   endtask

   // Returns at the negedge of the REQ cycle.
   task automatic issue_miss(input logic [31:0] a);
      wait_idle();
      miss_req  = 1'b1;
      miss_addr = a;
      @(negedge clk);
      miss_req  = 1'b0;
   endtask

   // Returns at the negedge one cycle after the last pulse was driven.
   task automatic feed(input logic [31:0] base, input int maxgap, input int nbeats);
      for (int i = 0; i < nbeats; i++) begin
         repeat ($urandom_range(0, maxgap)) begin
            bus_rd_data_ready = 1'b0;
            @(negedge clk);
         end
         bus_rd_data_ready = 1'b1;
         cpu_rd_data       = base + 32'(i);
         @(negedge clk);
      end
      bus_rd_data_ready = 1'b0;
   endtask

   initial begin
      int v0;
      int e0;
      int k;
      repeat (3) @(negedge clk);
      chk("rst_miss_ready", 32'(miss_ready), 32'd1);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_ar_en", 32'(axi_ar_en), 32'd0);
      chk("rst_valid", 32'(refill_valid), 32'd0);
      chk("rst_rd_addr", cpu_rd_addr, 32'h0);
      chk("rst_word", refill_word, 32'h0);
      chk_line("rst_line", refill_line, '0);
      reset = 1'b0;
      @(negedge clk);

      // Basic back-to-back refill; first beat lands in the REQ cycle.
      issue_miss(32'h1FC0_0014);
      chk("basic_ar_en", 32'(axi_ar_en), 32'd1);
      chk("basic_rd_addr", cpu_rd_addr, 32'h1FC0_0000);
      chk("basic_len", 32'(ar_burst_len), 32'd7);
      chk("basic_step", 32'(ar_burst_step), 32'd1);
      feed(32'hA0, 0, 8);
      chk("basic_valid", 32'(refill_valid), 32'd1);
      chk("basic_word", refill_word, 32'hA5);
      chk("basic_line_w7", refill_line[255:224], 32'hA7);
      chk("basic_refill_addr", refill_addr, 32'h1FC0_0000);
      chk("model_word_pin", m_line[m_widx], 32'hA5);

      // Gapped beats, then spurious pulses in DONE, GAP and IDLE.
      v0 = valid_cnt;
      issue_miss(32'h0000_1008);
      feed(32'hB0, 3, 8);
      bus_rd_data_ready = 1'b1;
      cpu_rd_data       = 32'h0000_DEAD;
      repeat (4) @(negedge clk);
      bus_rd_data_ready = 1'b0;
      chk("gap_valid_pulses", 32'(valid_cnt - v0), 32'd1);
      chk("gap_line_w0", refill_line[31:0], 32'hB0);
      chk("gap_line_w7", refill_line[255:224], 32'hB7);
      chk("gap_word", refill_word, 32'hB2);

      // Back-to-back misses with miss_req held high.
      wait_idle();
      miss_req  = 1'b1;
      miss_addr = 32'h0000_2000;
      @(negedge clk);
      feed(32'hC0, 1, 8);
      k = 0;
      while (axi_ar_en !== 1'b1 && k < 20) begin
         @(negedge clk);
         k++;
      end
      miss_req = 1'b0;
      chk("b2b_second_rise", 32'(axi_ar_en), 32'd1);
      chk("b2b_rise_spacing", 32'(last_rise_cyc - last_valid_cyc), 32'(GAP + 1));
      feed(32'hD0, 0, 8);
      chk("b2b_second_word", refill_word, 32'hD0);

      // Reset after four of eight beats, then a clean refill.
      issue_miss(32'h0000_0040);
      feed(32'hE0, 0, 4);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("rstmid_ar_en", 32'(axi_ar_en), 32'd0);
      chk("rstmid_miss_ready", 32'(miss_ready), 32'd1);
      chk_line("rstmid_line", refill_line, '0);
      issue_miss(32'h0000_0020);
      feed(32'hF0, 0, 8);
      chk("rstmid_valid", 32'(refill_valid), 32'd1);
      chk("rstmid_refill_addr", refill_addr, 32'h0000_0020);
      chk("rstmid_word", refill_word, 32'hF0);
      chk("rstmid_line_w3", refill_line[127:96], 32'hF3);

`ifdef ICACHE_CRITICAL_WORD_FWD_EN
      e0 = early_cnt;
      issue_miss(32'h0000_031C);
      feed(32'h70, 0, 8);
      chk("fwd_last_valid", 32'(early_valid), 32'd1);
      chk("fwd_last_word", early_word, 32'h77);
      chk("fwd_last_coincide", 32'(refill_valid), 32'd1);
      chk("fwd_last_count", 32'(early_cnt - e0), 32'd1);
      e0 = early_cnt;
      issue_miss(32'h0000_0400);
      feed(32'h80, 0, 1);
      chk("fwd_first_valid", 32'(early_valid), 32'd1);
      chk("fwd_first_word", early_word, 32'h80);
      feed(32'h81, 0, 7);
      chk("fwd_first_count", 32'(early_cnt - e0), 32'd1);
`else
      e0 = 0;
      if (e0 != 0) $display("unexpected");
`endif

      repeat (5) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

endmodule
